// File: rtl/io_reg_pkg.sv
// io_reg_pkg: shared state type, IO cell counts and one-hot helper for the IO register lane arbiter
package io_reg_pkg;
  localparam int IO_OUT_CELLS = 18;
  localparam int IO_IN_CELLS = 8;
  localparam int MAX_REQ = 8;
  typedef enum logic [1:0] {IDLE, DRIVE, WAIT, SAMPLE} state_t;
  // result is MAX_REQ wide; callers size-cast to their requester count
  function automatic logic [MAX_REQ-1:0] onehot(input int idx, input int n);
    logic [MAX_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_REQ; i++) v[i] = (i == idx) && (i < n);
    return v;
  endfunction
endpackage

// File: rtl/io_rr_pick.sv
// io_rr_pick: combinational rotating-priority picker, first set request at or after ptr (with wrap)
// ports: req (request vector), ptr (search start), grant (winning index), any_valid (some request set)
module io_rr_pick #(
  parameter int N = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] grant,
  output logic          any_valid
);
  int idx;
  // scan from the farthest offset down so the nearest request to ptr wins
  always_comb begin
    grant = '0;
    any_valid = 1'b0;
    idx = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      idx = idx >= N ? idx - N : idx;
      if (req[idx]) begin
        grant = PW'(idx);
        any_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/io_reg_lane_arbiter.sv
// io_reg_lane_arbiter: round-robin sharing of one IO register lane (OQI out, IQZ in) among NUM_REQ requesters
// ports: IQC clock, QRT async reset; req_valid/req_rd/req_data requests, req_ready one-hot accept;
//        OQI/oqi_en drive word to output cells; IQZ input cells; rsp_valid/rsp_data read response; busy
module io_reg_lane_arbiter
  import io_reg_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int OUT_W = IO_OUT_CELLS,
  parameter int IN_W = IO_IN_CELLS,
  parameter int TURNAROUND = 1
) (
  input  logic                     IQC,
  input  logic                     QRT,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_rd,
  input  logic [NUM_REQ*OUT_W-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [OUT_W-1:0]         OQI,
  output logic                     oqi_en,
  input  logic [IN_W-1:0]          IQZ,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [IN_W-1:0]          rsp_data,
  output logic                     busy
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [PW-1:0] rr_ptr, g, g_q;
  logic rd_q, any_valid, accept, done;
  io_rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req(req_valid),
    .ptr(rr_ptr),
    .grant(g),
    .any_valid(any_valid)
  );
  // reset gates the combinational accept so every output reads 0 while QRT is high
  assign accept = state == IDLE && any_valid && !QRT;
  assign done = (state == DRIVE && !rd_q) || state == SAMPLE;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    req_ready = '0;
    oqi_en = 1'b0;
    busy = state != IDLE;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = DRIVE;
          req_ready = NUM_REQ'(onehot(int'(g), NUM_REQ));
        end
      end
      DRIVE: begin
        oqi_en = 1'b1;
        cnt_n = 4'(TURNAROUND);
        state_n = !rd_q ? IDLE : TURNAROUND == 0 ? SAMPLE : WAIT;
      end
      WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) state_n = SAMPLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge IQC or posedge QRT) begin
    if (QRT) begin
      state <= IDLE;
      cnt <= '0;
      rr_ptr <= '0;
      g_q <= '0;
      rd_q <= 1'b0;
      OQI <= '0;
      rsp_valid <= '0;
      rsp_data <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      rsp_valid <= state == SAMPLE ? NUM_REQ'(onehot(int'(g_q), NUM_REQ)) : '0;
      if (accept) begin
        OQI <= req_data[int'(g)*OUT_W +: OUT_W];
        rd_q <= req_rd[g];
        g_q <= g;
      end
      if (state == SAMPLE) rsp_data <= IQZ;
      // explicit wrap compare keeps non-power-of-two requester counts in range
      if (done) rr_ptr <= g_q == PW'(NUM_REQ - 1) ? '0 : g_q + 1'b1;
    end
  end
endmodule
